// File: rtl/pico_instr_sequencer.sv
// Program store and instruction issue sequencer for a pico core.
// Loads 16-bit instructions as byte pairs, then feeds each one to the core
// as a lo/hi pair, lets it execute, and follows the core's PC between
// instructions until the program ends, a step limit is hit, or a halt
// request arrives.
module pico_instr_sequencer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       clear,
  input  logic       run,
  input  logic       halt,
  output logic [7:0] core_ui,
  output logic [7:0] core_uio,
  input  logic [4:0] core_pc,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [5:0] prog_len
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1;
  localparam int unsigned LW    = 6;
  localparam int unsigned PW    = 5;
  // Bit 7 of the low byte never reaches the core, so only 15 bits are kept.
  localparam int unsigned WW    = 15;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [SW-1:0] MAX_L   = SW'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_ISSUE_HI,
    S_EXEC,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] prog_len_nxt;
  logic [PW-1:0] idx, idx_nxt;
  logic [SW-1:0] steps, steps_nxt;
  logic [PW-1:0] pc_base, pc_base_nxt;
  logic          held_vld, held_vld_nxt;
  logic [6:0]    held_lo, held_lo_nxt;
  logic          timeout_nxt;
  logic          done_nxt;
  logic          busy_nxt;
  logic          ld_ready_nxt;
  logic [7:0]    core_ui_nxt;
  logic [7:0]    core_uio_nxt;
  logic [PW-1:0] pc_off;
  logic          store_we;
  logic [WW-1:0] rd_word;

  logic [WW-1:0] store [DEPTH];

  // Program store write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store[prog_len[AW-1:0]] <= {ld_data, held_lo};
    end
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_nxt    = state;
    prog_len_nxt = prog_len;
    idx_nxt      = idx;
    steps_nxt    = steps;
    pc_base_nxt  = pc_base;
    held_vld_nxt = held_vld;
    held_lo_nxt  = held_lo;
    timeout_nxt  = timeout;
    store_we     = 1'b0;
    pc_off       = core_pc - pc_base;

    case (state)
      S_IDLE: begin
        if (run && (prog_len != '0)) begin
          state_nxt   = S_ISSUE_LO;
          pc_base_nxt = core_pc;
          idx_nxt     = '0;
          steps_nxt   = '0;
          timeout_nxt = 1'b0;
        end else if (clear) begin
          prog_len_nxt = '0;
          held_vld_nxt = 1'b0;
        end else if (ld_valid && ld_ready) begin
          if (held_vld) begin
            store_we     = 1'b1;
            prog_len_nxt = prog_len + LW'(1);
            held_vld_nxt = 1'b0;
          end else begin
            held_lo_nxt  = ld_data[6:0];
            held_vld_nxt = 1'b1;
          end
        end
      end
      S_ISSUE_LO: state_nxt = S_ISSUE_HI;
      S_ISSUE_HI: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_SETTLE;
        steps_nxt = (steps == MAX_L) ? steps : steps + SW'(1);
      end
      S_SETTLE: begin
        idx_nxt = pc_off;
        if (halt) begin
          state_nxt = S_IDLE;
        end else if (steps == MAX_L) begin
          state_nxt   = S_DONE;
          timeout_nxt = 1'b1;
        end else if ({1'b0, pc_off} >= prog_len) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_ISSUE_LO;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    rd_word      = store[idx_nxt[AW-1:0]];
    core_ui_nxt  = 8'h00;
    core_uio_nxt = 8'h00;
    case (state_nxt)
      S_ISSUE_LO: core_ui_nxt = {1'b1, rd_word[6:0]};
      S_ISSUE_HI: begin
        core_ui_nxt  = 8'h80;
        core_uio_nxt = rd_word[WW-1:7];
      end
      default: ;
    endcase

    busy_nxt     = (state_nxt == S_ISSUE_LO) || (state_nxt == S_ISSUE_HI) ||
                   (state_nxt == S_EXEC)     || (state_nxt == S_SETTLE);
    done_nxt     = (state_nxt == S_DONE);
    ld_ready_nxt = (state_nxt == S_IDLE) && (prog_len_nxt < DEPTH_L);
  end

  // State and registered outputs; reset also drops core_ui[7] immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      prog_len <= '0;
      idx      <= '0;
      steps    <= '0;
      pc_base  <= '0;
      held_vld <= 1'b0;
      held_lo  <= '0;
      timeout  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ld_ready <= 1'b1;
      core_ui  <= '0;
      core_uio <= '0;
    end else begin
      state    <= state_nxt;
      prog_len <= prog_len_nxt;
      idx      <= idx_nxt;
      steps    <= steps_nxt;
      pc_base  <= pc_base_nxt;
      held_vld <= held_vld_nxt;
      held_lo  <= held_lo_nxt;
      timeout  <= timeout_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      ld_ready <= ld_ready_nxt;
      core_ui  <= core_ui_nxt;
      core_uio <= core_uio_nxt;
    end
  end

endmodule
